// File: rtl/approx_eval_pkg.sv
// rtl/approx_eval_pkg.sv - shared types and constants for approximate-multiplier evaluation
// Purpose: FSM state encoding, default operand width / window size and the
//          ED-width helper used by the monitor, its ED stage and its interface.
// Ports:   none (package).
package approx_eval_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_N_SAMPLES = 65536;

  // Error distance between two PW-bit unsigned products needs the full product width.
  function automatic int ed_width(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/approx_mul_err_monitor_if.sv
// rtl/approx_mul_err_monitor_if.sv - sample/stats bus of the error monitor
// Purpose: groups the start/sample handshake and the statistics outputs.
// Ports:   master = sample source / host side, slave = monitor side.
//          start, in_valid, a_in, b_in, prod_apx : master -> slave
//          in_ready, busy, done, stats_valid,
//          err_cnt, ed_sum, ed_max               : slave -> master
interface approx_mul_err_monitor_if
  import approx_eval_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int N_SAMPLES = DEF_N_SAMPLES
) ();

  localparam int PW    = ed_width(WIDTH);
  localparam int CNT_W = $clog2(N_SAMPLES + 1);
  localparam int SUM_W = PW + CNT_W;

  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [PW-1:0]    prod_apx;
  logic             busy;
  logic             done;
  logic             stats_valid;
  logic [CNT_W-1:0] err_cnt;
  logic [SUM_W-1:0] ed_sum;
  logic [PW-1:0]    ed_max;

  modport master (
    output start, in_valid, a_in, b_in, prod_apx,
    input  in_ready, busy, done, stats_valid, err_cnt, ed_sum, ed_max
  );

  modport slave (
    input  start, in_valid, a_in, b_in, prod_apx,
    output in_ready, busy, done, stats_valid, err_cnt, ed_sum, ed_max
  );

endinterface

// File: rtl/approx_ed_stage.sv
// rtl/approx_ed_stage.sv - two-stage exact multiply and error-distance pipeline
// Purpose: S1 registers the operands and approximate product; S2 registers
//          ED = |a*b - prod_apx| together with its valid.
// Ports:   clk, rst_n          clock, async active-low reset
//          valid_i, a_i, b_i,
//          apx_i               accepted sample
//          ed_o, valid_o       error distance and its valid (S2 output)
//          pend_o              any stage holds a sample
module approx_ed_stage
  import approx_eval_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  localparam int PW   = ed_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [PW-1:0]    apx_i,
  output logic [PW-1:0]    ed_o,
  output logic             valid_o,
  output logic             pend_o
);

  logic [WIDTH-1:0] a_q, b_q;
  logic [PW-1:0]    apx_q, ed_q, ed_d, exact;
  logic             v1_q, v2_q;

  always_comb begin
    exact = PW'(a_q) * PW'(b_q);
    // Overestimates and underestimates both count as plain distance.
    ed_d  = (exact >= apx_q) ? (exact - apx_q) : (apx_q - exact);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      apx_q <= '0;
      v1_q  <= 1'b0;
      ed_q  <= '0;
      v2_q  <= 1'b0;
    end else begin
      v1_q <= valid_i;
      if (valid_i) begin
        a_q   <= a_i;
        b_q   <= b_i;
        apx_q <= apx_i;
      end
      v2_q <= v1_q;
      if (v1_q) ed_q <= ed_d;
    end
  end

  assign ed_o    = ed_q;
  assign valid_o = v2_q;
  assign pend_o  = v1_q | v2_q;

endmodule

// File: rtl/approx_mul_err_monitor.sv
// rtl/approx_mul_err_monitor.sv - windowed error statistics for 8x8 approximate multipliers
// Purpose: accepts N_SAMPLES (a, b, prod_apx) samples per window, recomputes the
//          exact product and accumulates error count, ED sum (saturating) and max ED.
// Ports:   clk, rst_n  clock, async active-low reset
//          bus         approx_mul_err_monitor_if.slave (handshake + stats)
module approx_mul_err_monitor
  import approx_eval_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int N_SAMPLES = DEF_N_SAMPLES
) (
  input logic                      clk,
  input logic                      rst_n,
  approx_mul_err_monitor_if.slave  bus
);

  localparam int PW    = ed_width(WIDTH);
  localparam int CNT_W = $clog2(N_SAMPLES + 1);
  localparam int SUM_W = PW + CNT_W;
  localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N_SAMPLES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [SUM_W:0]   sum_ext;
  logic [PW-1:0]    max_q, max_d;
  logic             done_q, done_d;
  logic             sv_q, sv_d;
  logic             accept, clr;
  logic [PW-1:0]    ed;
  logic             ed_valid, pend;

  assign bus.in_ready = (state_q == RUN) && (cnt_q < N_CNT);
  assign accept       = bus.in_valid && bus.in_ready;

  approx_ed_stage #(.WIDTH(WIDTH)) u_ed (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (accept),
    .a_i     (bus.a_in),
    .b_i     (bus.b_in),
    .apx_i   (bus.prod_apx),
    .ed_o    (ed),
    .valid_o (ed_valid),
    .pend_o  (pend)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    sv_d    = sv_q;
    clr     = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = RUN;
          cnt_d   = '0;
          sv_d    = 1'b0;
          clr     = 1'b1;
        end
      end
      RUN: begin
        if (accept) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == N_CNT) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Leaves one cycle after the last sample has left S2 and been accumulated.
        if (!pend) begin
          state_d = DONE;
          done_d  = 1'b1;
          sv_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    err_d   = err_q;
    sum_d   = sum_q;
    max_d   = max_q;
    sum_ext = {1'b0, sum_q} + (SUM_W + 1)'(ed);
    if (clr) begin
      err_d = '0;
      sum_d = '0;
      max_d = '0;
    end else if (ed_valid) begin
      err_d = err_q + CNT_W'(ed != '0);
      sum_d = sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
      if (ed > max_q) max_d = ed;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= '0;
      sum_q   <= '0;
      max_q   <= '0;
      done_q  <= 1'b0;
      sv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      sum_q   <= sum_d;
      max_q   <= max_d;
      done_q  <= done_d;
      sv_q    <= sv_d;
    end
  end

  assign bus.busy        = (state_q == RUN) || (state_q == DRAIN);
  assign bus.done        = done_q;
  assign bus.stats_valid = sv_q;
  assign bus.err_cnt     = err_q;
  assign bus.ed_sum      = sum_q;
  assign bus.ed_max      = max_q;

endmodule

// File: tb/tb_approx_mul_err_monitor.sv
// tb/tb_approx_mul_err_monitor.sv - directed self-checking bench for approx_mul_err_monitor
module tb_approx_mul_err_monitor;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  approx_mul_err_monitor_if #(.WIDTH(8), .N_SAMPLES(4))     b4 ();
  approx_mul_err_monitor_if #(.WIDTH(8), .N_SAMPLES(65536)) b64 ();

  approx_mul_err_monitor #(.WIDTH(8), .N_SAMPLES(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b4)
  );

  approx_mul_err_monitor #(.WIDTH(8), .N_SAMPLES(65536)) dut64 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b64)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ed_of(input logic [7:0] a, input logic [7:0] b, input logic [15:0] apx);
    int exact;
    exact = int'(a) * int'(b);
    return (exact >= int'(apx)) ? exact - int'(apx) : int'(apx) - exact;
  endfunction

  // Stand-in approximate multiplier: low three product bits forced up or down.
  function automatic logic [15:0] apx_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    return (a[0] & b[0]) ? (p | 16'h0007) : (p & 16'hFFF8);
  endfunction

  task automatic start4();
    b4.start = 1'b1;
    tick();
    b4.start = 1'b0;
  endtask

  task automatic send4(input logic [7:0] a, input logic [7:0] b, input logic [15:0] apx);
    bit got;
    got = 1'b0;
    b4.a_in = a;
    b4.b_in = b;
    b4.prod_apx = apx;
    b4.in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (b4.in_ready) begin
        got = 1'b1;
        tick();
        break;
      end
      tick();
    end
    b4.in_valid = 1'b0;
    if (!got) check("send_timeout", 0, 1);
  endtask

  // Called right after the edge that took the final sample.
  task automatic wait_done4(input string tag);
    int lat;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (b4.done) begin
        lat = i;
        break;
      end
    end
    check({tag, "_done_lat"}, lat, 3);
    check({tag, "_sv_at_done"}, b4.stats_valid, 1);
    check({tag, "_busy_at_done"}, b4.busy, 0);
    tick();
    check({tag, "_done_pulse"}, b4.done, 0);
    check({tag, "_sv_hold"}, b4.stats_valid, 1);
  endtask

  task automatic stats4(input string tag, input int e, input longint s, input int m);
    check({tag, "_err_cnt"}, b4.err_cnt, e);
    check({tag, "_ed_sum"}, b4.ed_sum, s);
    check({tag, "_ed_max"}, b4.ed_max, m);
  endtask

  task automatic outs_zero4(input string tag);
    check({tag, "_in_ready"}, b4.in_ready, 0);
    check({tag, "_busy"}, b4.busy, 0);
    check({tag, "_done"}, b4.done, 0);
    check({tag, "_sv"}, b4.stats_valid, 0);
    stats4(tag, 0, 0, 0);
  endtask

  initial begin
    int acc;
    int m_err;
    int m_max;
    int d;
    int lat;
    longint m_sum;
    logic [7:0] ra, rb;
    logic [15:0] rp;

    n_vec = 0;
    n_bad = 0;
    b4.start = 0; b4.in_valid = 0; b4.a_in = 0; b4.b_in = 0; b4.prod_apx = 0;
    b64.start = 0; b64.in_valid = 0; b64.a_in = 0; b64.b_in = 0; b64.prod_apx = 0;
    rst_n = 1'b0;
    tick();
    tick();
    outs_zero4("reset");
    rst_n = 1'b1;
    tick();

    // 1: all-exact window
    start4();
    check("t1_busy", b4.busy, 1);
    check("t1_in_ready", b4.in_ready, 1);
    send4(3, 7, 21);
    send4(255, 255, 65025);
    send4(0, 99, 0);
    send4(128, 2, 256);
    check("t1_ready_after_fill", b4.in_ready, 0);
    wait_done4("t1");
    stats4("t1", 0, 0, 0);

    // 2: known errors, including an overestimate
    start4();
    check("t2_sv_cleared", b4.stats_valid, 0);
    send4(15, 15, 200);
    send4(3, 5, 15);
    send4(255, 255, 65025);
    send4(16, 16, 260);
    wait_done4("t2");
    stats4("t2", 2, 29, 25);

    // 3: random gaps, in_valid held after the window fills
    start4();
    acc = 0; m_err = 0; m_sum = 0; m_max = 0;
    for (int c = 0; c < 200 && acc < 4; c++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rp = ($urandom_range(0, 1) == 1) ? 16'(ra) * 16'(rb) : 16'($urandom);
      b4.a_in = ra; b4.b_in = rb; b4.prod_apx = rp;
      b4.in_valid = 1'($urandom_range(0, 1));
      if (b4.in_valid && b4.in_ready) begin
        acc++;
        d = ed_of(ra, rb, rp);
        if (d != 0) m_err++;
        m_sum += d;
        if (d > m_max) m_max = d;
      end
      tick();
    end
    b4.in_valid = 1'b1;
    check("t3_accepts", acc, 4);
    check("t3_ready_after_fill", b4.in_ready, 0);
    wait_done4("t3");
    check("t3_ready_done", b4.in_ready, 0);
    b4.in_valid = 1'b0;
    stats4("t3", m_err, m_sum, m_max);

    // 4: start during RUN is ignored
    start4();
    send4(2, 3, 7);
    send4(10, 10, 100);
    start4();
    check("t4_busy_kept", b4.busy, 1);
    check("t4_ready_kept", b4.in_ready, 1);
    send4(7, 7, 40);
    send4(1, 1, 1);
    wait_done4("t4");
    stats4("t4", 2, 10, 9);

    // 5: reset mid-DRAIN, then a fresh window
    start4();
    send4(15, 15, 200);
    send4(3, 5, 15);
    send4(255, 255, 65025);
    send4(16, 16, 260);
    check("t5_busy_drain", b4.busy, 1);
    check("t5_max_partial", b4.ed_max, 25);
    #2;
    rst_n = 1'b0;
    #1;
    outs_zero4("t5_rst");
    tick();
    rst_n = 1'b1;
    tick();
    start4();
    send4(16, 16, 260);
    send4(255, 255, 65025);
    send4(3, 5, 15);
    send4(15, 15, 200);
    wait_done4("t5");
    stats4("t5", 2, 29, 25);

    // 6: full 65536-sample sweep against the reference model
    b64.start = 1'b1;
    tick();
    b64.start = 1'b0;
    acc = 0; m_err = 0; m_sum = 0; m_max = 0;
    b64.in_valid = 1'b1;
    for (int c = 0; c < 70000 && acc < 65536; c++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rp = apx_mul(ra, rb);
      b64.a_in = ra; b64.b_in = rb; b64.prod_apx = rp;
      if (b64.in_ready) begin
        acc++;
        d = ed_of(ra, rb, rp);
        if (d != 0) m_err++;
        m_sum += d;
        if (d > m_max) m_max = d;
      end
      tick();
    end
    b64.in_valid = 1'b0;
    check("t6_accepts", acc, 65536);
    check("t6_ready_after_fill", b64.in_ready, 0);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (b64.done) begin
        lat = i;
        break;
      end
    end
    check("t6_done_lat", lat, 3);
    check("t6_sv", b64.stats_valid, 1);
    check("t6_err_cnt", b64.err_cnt, m_err);
    check("t6_ed_sum", b64.ed_sum, m_sum);
    check("t6_ed_max", b64.ed_max, m_max);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
